// File: rtl/muldiv_pkg.sv
// Shared types for the EX-stage multiply/divide sequencer: op codes and FSM states.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MFHI    = 4'd5,
        MFLO    = 4'd6,
        MTHI    = 4'd7,
        MTLO    = 4'd8
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_md_op(md_op_t op);
        return (op != OP_NONE) && (op <= MTLO);
    endfunction

    function automatic logic is_iter_op(md_op_t op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Pipeline-side bundle of the multiply/divide unit: op request, flush, status and HI/LO view.
interface muldiv_if #(parameter int WIDTH = 32);
    import muldiv_pkg::*;

    logic             op_valid;
    md_op_t           op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             stall_req;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_data;

    modport master (
        output op_valid, op, rs_val, rt_val, flush,
        input  stall_req, busy, done, div0, hi, lo, mf_data
    );

    modport slave (
        input  op_valid, op, rs_val, rt_val, flush,
        output stall_req, busy, done, div0, hi, lo, mf_data
    );
endinterface

// File: rtl/muldiv_iter.sv
// One radix-2 step: shift-add for multiply, shift-subtract-restore for divide.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] mq_next
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum     = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
        shifted = {acc, mq[WIDTH-1]};
        ge      = shifted >= {1'b0, opb};
        // When ge holds the true difference is below 2**WIDTH, so the truncated subtract is exact.
        diff    = shifted[WIDTH-1:0] - opb;
        if (is_div) begin
            acc_next = ge ? diff : shifted[WIDTH-1:0];
            mq_next  = {mq[WIDTH-2:0], ge};
        end else begin
            acc_next = sum[WIDTH:1];
            mq_next  = {sum[0], mq[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/DIV sequencer owning HI/LO; stalls dependent md ops while an operation is in flight.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   acc_reg, mq_reg, opb_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               is_div_reg, neg_q_reg, neg_r_reg, dz_reg;
    logic               done_reg, div0_reg;

    logic               accept, signed_op, sa, sb, op_div;
    logic [WIDTH-1:0]   a_abs, b_abs, acc_next, mq_next;
    logic [WIDTH-1:0]   q_fix, r_fix;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign accept = bus.op_valid && (state_reg == IDLE) && !bus.flush && is_md_op(bus.op);

    always_comb begin
        signed_op = (bus.op == MULT) || (bus.op == DIV);
        op_div    = (bus.op == DIV) || (bus.op == DIVU);
        sa        = signed_op && bus.rs_val[WIDTH-1];
        sb        = signed_op && bus.rt_val[WIDTH-1];
        a_abs     = sa ? -bus.rs_val : bus.rs_val;
        b_abs     = sb ? -bus.rt_val : bus.rt_val;
        prod      = {acc_reg, mq_reg};
        prod_fix  = neg_q_reg ? -prod : prod;
        // Divide-by-zero reports an all-ones quotient regardless of operand signs.
        q_fix     = dz_reg ? '1 : (neg_q_reg ? -mq_reg : mq_reg);
        r_fix     = neg_r_reg ? -acc_reg : acc_reg;
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div   (is_div_reg),
        .acc      (acc_reg),
        .mq       (mq_reg),
        .opb      (opb_reg),
        .acc_next (acc_next),
        .mq_next  (mq_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && is_iter_op(bus.op)) state_next = CALC;
            CALC: begin
                if (bus.flush)          state_next = IDLE;
                else if (cnt_reg == '0) state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mq_reg     <= '0;
            opb_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            dz_reg     <= 1'b0;
            done_reg   <= 1'b0;
            div0_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: if (accept) begin
                    div0_reg <= 1'b0;
                    if (bus.op == MTHI) hi_reg <= bus.rs_val;
                    if (bus.op == MTLO) lo_reg <= bus.rs_val;
                    if (is_iter_op(bus.op)) begin
                        acc_reg    <= '0;
                        mq_reg     <= op_div ? a_abs : b_abs;
                        opb_reg    <= op_div ? b_abs : a_abs;
                        is_div_reg <= op_div;
                        neg_q_reg  <= sa ^ sb;
                        neg_r_reg  <= sa;
                        dz_reg     <= op_div && (bus.rt_val == '0);
                        cnt_reg    <= CNT_W'(WIDTH - 1);
                    end
                end
                CALC: if (!bus.flush) begin
                    acc_reg <= acc_next;
                    mq_reg  <= mq_next;
                    cnt_reg <= cnt_reg - 1'b1;
                end
                FIX: if (!bus.flush) begin
                    if (is_div_reg) begin
                        lo_reg <= q_fix;
                        hi_reg <= r_fix;
                    end else begin
                        lo_reg <= prod_fix[WIDTH-1:0];
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                    end
                    done_reg <= 1'b1;
                    if (dz_reg) div0_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.mf_data = '0;
        if (bus.op == MFHI)      bus.mf_data = hi_reg;
        else if (bus.op == MFLO) bus.mf_data = lo_reg;
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.stall_req = bus.op_valid && (state_reg != IDLE);
    assign bus.done      = done_reg;
    assign bus.div0      = div0_reg;
    assign bus.hi        = hi_reg;
    assign bus.lo        = lo_reg;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: arithmetic results, timing, stall, flush and async reset.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.rs_val   = a;
        bus.rt_val   = b;
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.op       = OP_NONE;
    endtask

    task automatic run_op(input string tag, input md_op_t o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        int d;
        n = 0;
        d = 0;
        issue(o, a, b);
        while (bus.busy && n < 100) begin
            if (bus.done) d++;
            n++;
            @(negedge clk);
        end
        check({tag, "_timeout"}, 64'(n < 100), 64'd1);
        check({tag, "_busy_cycles"}, 64'(n), 64'd33);
        check({tag, "_hi"}, 64'(bus.hi), 64'(eh));
        check({tag, "_lo"}, 64'(bus.lo), 64'(el));
        if (bus.done) d++;
        @(negedge clk);
        if (bus.done) d++;
        check({tag, "_done_pulses"}, 64'(d), 64'd1);
        $display("txn %s a=%h b=%h hi=%h lo=%h div0=%0b", tag, a, b, bus.hi, bus.lo, bus.div0);
    endtask

    initial begin
        int n;
        int d;
        rst_n        = 1'b0;
        bus.op_valid = 1'b0;
        bus.op       = OP_NONE;
        bus.rs_val   = '0;
        bus.rt_val   = '0;
        bus.flush    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_div0", 64'(bus.div0), 64'd0);
        rst_n = 1'b1;
        $display("txn reset released");

        run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", MULT, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
        run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negb", DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_zero", DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        check("div0_set", 64'(bus.div0), 64'd1);
        repeat (3) @(negedge clk);
        check("div0_sticky", 64'(bus.div0), 64'd1);
        issue(MTLO, 32'd5, 32'd0);
        check("mtlo_lo", 64'(bus.lo), 64'd5);
        check("mtlo_div0_clr", 64'(bus.div0), 64'd0);
        check("mtlo_idle", 64'(bus.busy), 64'd0);
        check("mtlo_hi_kept", 64'(bus.hi), 64'd100);
        $display("txn mtlo lo=%h div0=%0b", bus.lo, bus.div0);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        check("div_ovf_noflag", 64'(bus.div0), 64'd0);
        run_op("divu_rem", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // MFLO held behind an in-flight MULT: 3 * -5 = -15
        issue(MULT, 32'd3, 32'hFFFF_FFFB);
        bus.op_valid = 1'b1;
        bus.op       = MFLO;
        n = 0;
        while (bus.busy && n < 100) begin
            check("stall_hold", 64'(bus.stall_req), 64'd1);
            n++;
            @(negedge clk);
        end
        check("stall_timeout", 64'(n < 100), 64'd1);
        check("stall_release", 64'(bus.stall_req), 64'd0);
        check("mflo_data", 64'(bus.mf_data), 64'hFFFF_FFF1);
        bus.op = MFHI;
        #1;
        check("mfhi_data", 64'(bus.mf_data), 64'hFFFF_FFFF);
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.op       = OP_NONE;
        $display("txn mult+mflo stall_cycles=%0d lo=%h", n, bus.lo);

        issue(MTHI, 32'hAAAA_0000, 32'd0);
        issue(MTLO, 32'h0000_5555, 32'd0);
        check("mthi_hi", 64'(bus.hi), 64'hAAAA_0000);
        check("mtlo2_lo", 64'(bus.lo), 64'h0000_5555);

        // flush in IDLE blocks acceptance
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = MTHI;
        bus.rs_val   = 32'hDEAD_BEEF;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.op       = OP_NONE;
        bus.flush    = 1'b0;
        check("flush_idle_block", 64'(bus.hi), 64'hAAAA_0000);
        check("flush_idle_busy", 64'(bus.busy), 64'd0);
        $display("txn flushed mthi hi=%h", bus.hi);

        // flush during CALC
        issue(DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        check("flush_calc_busy", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_calc_idle", 64'(bus.busy), 64'd0);
        d = 0;
        repeat (40) begin
            if (bus.done) d++;
            @(negedge clk);
        end
        check("flush_calc_nodone", 64'(d), 64'd0);
        check("flush_calc_hi", 64'(bus.hi), 64'hAAAA_0000);
        check("flush_calc_lo", 64'(bus.lo), 64'h0000_5555);
        $display("txn div flushed in calc hi=%h lo=%h", bus.hi, bus.lo);

        // flush on the FIX edge suppresses the write
        issue(DIVU, 32'd1000, 32'd3);
        repeat (32) @(negedge clk);
        check("flush_fix_busy", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_fix_idle", 64'(bus.busy), 64'd0);
        check("flush_fix_nodone", 64'(bus.done), 64'd0);
        check("flush_fix_hi", 64'(bus.hi), 64'hAAAA_0000);
        check("flush_fix_lo", 64'(bus.lo), 64'h0000_5555);
        $display("txn divu flushed in fix hi=%h lo=%h", bus.hi, bus.lo);

        // asynchronous reset in the middle of a DIV
        issue(DIV, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_hi", 64'(bus.hi), 64'd0);
        check("arst_lo", 64'(bus.lo), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        check("arst_div0", 64'(bus.div0), 64'd0);
        $display("txn async reset mid-div hi=%h lo=%h", bus.hi, bus.lo);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_divu", DIVU, 32'd1000, 32'd3, 32'd1, 32'd333);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
